// File: rtl/display_multiplex_dimmable.sv
// Time-multiplexed 7-segment display driver with PWM dimming, per-digit blink,
// leading-zero blanking, a double-buffered frame-aligned load and a dead cycle at the start of each slot.
module display_multiplex_dimmable #(
    parameter int CLOCK_HZ           = 10_000_000,
    parameter int DIGITS             = 8,
    parameter int SWITCH_PERIOD_US   = 1000,
    parameter int PWM_BITS           = 4,
    parameter int BLINK_PERIOD_MS    = 500,
    parameter bit CATHODE_ACTIVE_LOW = 1'b1,
    parameter bit SEGMENT_ACTIVE_LOW = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Data_i,
    input  logic [DIGITS-1:0]     DecimalPoints_i,
    input  logic [DIGITS-1:0]     Blink_i,
    input  logic                  BlankZeros_i,
    input  logic                  Load_i,
    input  logic [PWM_BITS-1:0]   Brightness_i,
    output logic [DIGITS-1:0]     Cathodes_o,
    output logic [7:0]            Segments_o,
    output logic                  Frame_o
);

    localparam longint TICKS_L  = longint'(CLOCK_HZ) * longint'(SWITCH_PERIOD_US) / 64'd1_000_000;
    localparam int     TICKS    = int'(TICKS_L);
    localparam int     SLOT_W   = $clog2(TICKS);
    localparam int     SEL_W    = $clog2(DIGITS);
    localparam int     MS_TICKS = CLOCK_HZ / 1000;
    localparam int     MS_W     = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam int     BLINK_W  = (BLINK_PERIOD_MS > 1) ? $clog2(BLINK_PERIOD_MS) : 1;

    localparam logic [DIGITS-1:0] CATH_IDLE = CATHODE_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_IDLE  = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [SLOT_W-1:0]   slot_cnt_q,    slot_cnt_d;
    logic [SEL_W-1:0]    sel_q,         sel_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,     pwm_cnt_d;
    logic [MS_W-1:0]     ms_cnt_q,      ms_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q,   blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [4*DIGITS-1:0] sh_data_q,     sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q,       sh_dp_d;
    logic [DIGITS-1:0]   sh_blink_q,    sh_blink_d;
    logic [4*DIGITS-1:0] act_data_q,    act_data_d;
    logic [DIGITS-1:0]   act_dp_q,      act_dp_d;
    logic [DIGITS-1:0]   act_blink_q,   act_blink_d;
    logic                pending_q,     pending_d;
    logic [DIGITS-1:0]   cathodes_q,    cathodes_d;
    logic [7:0]          segments_q,    segments_d;
    logic                frame_q,       frame_d;

    logic                slot_wrap, sel_wrap, boundary, ms_tick, blink_wrap;
    logic                lead_run;
    logic [DIGITS-1:0]   lead_blank;
    logic [3:0]          nibble;
    logic                digit_blank, pwm_on, digit_en;
    logic [7:0]          seg_raw;
    logic [DIGITS-1:0]   cath_raw;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Scan, PWM and blink timebases
    always_comb begin
        slot_wrap     = (slot_cnt_q == SLOT_W'(TICKS - 1));
        sel_wrap      = (sel_q == SEL_W'(DIGITS - 1));
        boundary      = slot_wrap && sel_wrap;
        slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        sel_d         = sel_q;
        if (slot_wrap) sel_d = sel_wrap ? '0 : sel_q + 1'b1;
        pwm_cnt_d     = (slot_cnt_q == '0) ? '0 : pwm_cnt_q + 1'b1;
        ms_tick       = (ms_cnt_q == MS_W'(MS_TICKS - 1));
        ms_cnt_d      = ms_tick ? '0 : ms_cnt_q + 1'b1;
        blink_wrap    = (blink_cnt_q == BLINK_W'(BLINK_PERIOD_MS - 1));
        blink_cnt_d   = blink_cnt_q;
        if (ms_tick) blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ (ms_tick && blink_wrap);
    end

    // Active buffer is swapped only at the frame boundary so a frame never mixes old and new data
    always_comb begin
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blink_d  = sh_blink_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blink_d = act_blink_q;
        pending_d   = pending_q;
        if (boundary && pending_q) begin
            act_data_d  = sh_data_q;
            act_dp_d    = sh_dp_q;
            act_blink_d = sh_blink_q;
            pending_d   = 1'b0;
        end
        if (Load_i) begin
            sh_data_d  = Data_i;
            sh_dp_d    = DecimalPoints_i;
            sh_blink_d = Blink_i;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        lead_blank = '0;
        lead_run   = BlankZeros_i;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_run      = lead_run && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            lead_blank[i] = lead_run;
        end
    end

    always_comb begin
        nibble      = act_data_q[{sel_q, 2'b00} +: 4];
        digit_blank = lead_blank[sel_q] || (blink_phase_q && act_blink_q[sel_q]);
        seg_raw     = digit_blank ? 8'h00 : {act_dp_q[sel_q], glyph(nibble)};
        pwm_on      = (Brightness_i == '1) || (pwm_cnt_q < Brightness_i);
        digit_en    = (slot_cnt_q != '0) && pwm_on;
        cath_raw    = digit_en ? (DIGITS'(1) << sel_q) : '0;
        cathodes_d  = CATHODE_ACTIVE_LOW ? ~cath_raw : cath_raw;
        segments_d  = SEGMENT_ACTIVE_LOW ? ~seg_raw : seg_raw;
        frame_d     = (slot_cnt_q == '0) && (sel_q == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            slot_cnt_q    <= '0;
            sel_q         <= '0;
            pwm_cnt_q     <= '0;
            ms_cnt_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_data_q     <= '0;
            sh_dp_q       <= '0;
            sh_blink_q    <= '0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_blink_q   <= '0;
            pending_q     <= 1'b0;
            cathodes_q    <= CATH_IDLE;
            segments_q    <= SEG_IDLE;
            frame_q       <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            sel_q         <= sel_d;
            pwm_cnt_q     <= pwm_cnt_d;
            ms_cnt_q      <= ms_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_data_q     <= sh_data_d;
            sh_dp_q       <= sh_dp_d;
            sh_blink_q    <= sh_blink_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_blink_q   <= act_blink_d;
            pending_q     <= pending_d;
            cathodes_q    <= cathodes_d;
            segments_q    <= segments_d;
            frame_q       <= frame_d;
        end
    end

    assign Cathodes_o = cathodes_q;
    assign Segments_o = segments_q;
    assign Frame_o    = frame_q;

endmodule

// File: tb/tb_display_multiplex_dimmable.sv
// Bench for display_multiplex_dimmable: directed scenarios plus random loads, every output pin
// checked each cycle against a cycle-count-based model of the scan, PWM, blink and buffering rules.
module tb_display_multiplex_dimmable;

    localparam int DIG   = 4;
    localparam int TK    = 10;
    localparam int FRAME = DIG * TK;
    localparam int HALF  = 10_000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Data_i = '0;
    logic [3:0]  DecimalPoints_i = '0;
    logic [3:0]  Blink_i = '0;
    logic        BlankZeros_i = 1'b0;
    logic        Load_i = 1'b0;
    logic [1:0]  Brightness_i = '0;
    logic [3:0]  Cathodes_o;
    logic [7:0]  Segments_o;
    logic        Frame_o;

    display_multiplex_dimmable #(
        .CLOCK_HZ(10_000_000), .DIGITS(DIG), .SWITCH_PERIOD_US(1), .PWM_BITS(2),
        .BLINK_PERIOD_MS(1), .CATHODE_ACTIVE_LOW(1'b1), .SEGMENT_ACTIVE_LOW(1'b0)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Data_i(Data_i), .DecimalPoints_i(DecimalPoints_i),
        .Blink_i(Blink_i), .BlankZeros_i(BlankZeros_i), .Load_i(Load_i),
        .Brightness_i(Brightness_i), .Cathodes_o(Cathodes_o), .Segments_o(Segments_o),
        .Frame_o(Frame_o)
    );

    always #5 Clock = ~Clock;

    int cmp  = 0;
    int mism = 0;
    int m    = 0;
    logic [15:0] act_data = '0, sh_data = '0;
    logic [3:0]  act_dp = '0, sh_dp = '0, act_bl = '0, sh_bl = '0;
    bit          pending = 1'b0;
    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s m=%0d observed=%h expected=%h", tag, m, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = 0;
        act_data = '0; sh_data = '0;
        act_dp = '0; sh_dp = '0; act_bl = '0; sh_bl = '0;
        pending = 1'b0;
    endtask

    // Pins after an edge show the scan position m reached before that edge
    task automatic tick();
        int slot, sel;
        bit en, lz, blk;
        logic [3:0] ec;
        logic [7:0] es;
        logic       ef;
        slot = m % TK;
        sel  = (m / TK) % DIG;
        en   = (slot != 0) && (Brightness_i == 2'd3 || ((slot - 1) % 4) < int'(Brightness_i));
        ec   = en ? ~(4'b0001 << sel) : 4'hF;
        lz   = BlankZeros_i && (sel > 0);
        for (int j = sel; j < DIG; j++)
            if (act_data[4*j +: 4] != 4'h0 || act_dp[j]) lz = 1'b0;
        blk  = ((m / HALF) % 2 == 1) && act_bl[sel];
        es   = (lz || blk) ? 8'h00 : {act_dp[sel], glyph_tab[act_data[4*sel +: 4]]};
        ef   = (slot == 0) && (sel == 0);
        @(posedge Clock);
        if ((m % FRAME == FRAME - 1) && pending) begin
            act_data = sh_data; act_dp = sh_dp; act_bl = sh_bl;
            pending  = 1'b0;
        end
        if (Load_i) begin
            sh_data = Data_i; sh_dp = DecimalPoints_i; sh_bl = Blink_i;
            pending = 1'b1;
        end
        m++;
        #1;
        chk("cathodes", {4'b0, Cathodes_o}, {4'b0, ec});
        chk("segments", Segments_o, es);
        chk("frame", {7'b0, Frame_o}, {7'b0, ef});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < FRAME && (m % FRAME) != p; k++) tick();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        Data_i = d; DecimalPoints_i = dp; Blink_i = bl; Load_i = 1'b1;
        tick();
        Load_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_cathodes", {4'b0, Cathodes_o}, 8'h0F);
        chk("rst_segments", Segments_o, 8'h00);
        chk("rst_frame", {7'b0, Frame_o}, 8'h00);
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();

        // BEEF at full brightness, visible only after the next frame boundary
        Brightness_i = 2'd3;
        run(5);
        load(16'hBEEF, 4'h0, 4'h0);
        run(2 * FRAME);

        Brightness_i = 2'd1;
        run(FRAME);
        Brightness_i = 2'd0;
        run(FRAME);
        Brightness_i = 2'd2;
        run(FRAME);
        Brightness_i = 2'd3;

        // Leading-zero blanking, then a DP stopping the blanking run
        BlankZeros_i = 1'b1;
        load(16'h0070, 4'h0, 4'h0);
        run(2 * FRAME);
        load(16'h0070, 4'b1000, 4'h0);
        run(2 * FRAME);
        BlankZeros_i = 1'b0;

        // Two loads in one frame: last wins
        wait_pos(2);
        load(16'h1234, 4'h0, 4'h0);
        run(5);
        load(16'h5678, 4'h0, 4'h0);
        run(2 * FRAME);

        // Load landing exactly on the boundary cycle
        wait_pos(FRAME - 1);
        load(16'h9ABC, 4'b0101, 4'h0);
        run(2 * FRAME);

        // Blink on digit 1 across two phase toggles
        load(16'h1234, 4'h0, 4'b0010);
        run(2 * HALF + 3 * FRAME);

        for (int k = 0; k < 3000; k++) begin
            Load_i = ($urandom_range(0, 29) == 0);
            if (Load_i) begin
                Data_i = 16'($urandom);
                DecimalPoints_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                Blink_i = 4'($urandom);
                if ($urandom_range(0, 1) == 0) Data_i = Data_i & 16'h00FF;
            end
            if ($urandom_range(0, 49) == 0) Brightness_i = 2'($urandom);
            if ($urandom_range(0, 99) == 0) BlankZeros_i = ~BlankZeros_i;
            tick();
        end
        Load_i = 1'b0;
        Brightness_i = 2'd3;
        BlankZeros_i = 1'b0;

        // Asynchronous reset mid-slot while digit 2 is being scanned
        load(16'h4321, 4'h0, 4'h0);
        run(FRAME);
        wait_pos(2 * TK + 4);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_cathodes", {4'b0, Cathodes_o}, 8'h0F);
        chk("midrst_segments", Segments_o, 8'h00);
        chk("midrst_frame", {7'b0, Frame_o}, 8'h00);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        run(2 * FRAME);
        BlankZeros_i = 1'b1;
        run(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
